sprite_ram_loader: RTL and testbench
====================================

SPRITE_RAM_LOADER -- requirements
Module: sprite_ram_loader

Interface
REQ-001 SHALL have parameter SPRITE_W, default 56, sprite width in pixels.
REQ-002 SHALL have parameter SPRITE_H, default 28, sprite height in pixels.
REQ-003 SHALL have parameter DATA_W, default 5, palette index width.
REQ-004 SHALL have parameter ADDR_W, default 19, frame RAM address width.
REQ-005 SHALL have port Clk  input  1  single system clock; all logic on posedge.
REQ-006 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to load one sprite.
REQ-008 SHALL have port base_address  input  ADDR_W  first RAM address, sampled on accepted start.
REQ-009 SHALL have port pix_valid  input  1  source pixel byte valid.
REQ-010 SHALL have port pix_data  input  8  [4:0] palette index; [7:5] run length minus 1 (RLE builds only).
REQ-011 SHALL have port pix_ready  output  1  loader accepts pix_data this cycle.
REQ-012 SHALL have port we  output  1  frame RAM write enable.
REQ-013 SHALL have port write_address  output  ADDR_W  frame RAM write address.
REQ-014 SHALL have port data_In  output  DATA_W  frame RAM write data.
REQ-015 SHALL have port busy  output  1  high from accepted start until done.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last write.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN (RLE only), DONE.
REQ-018 IDLE: start=1 -> LOAD; latch base_address; clear pixel counter; busy=1 next cycle.
REQ-019 SHALL ignore start while busy=1.
REQ-020 pix_ready SHALL be 1 only in LOAD; a byte is accepted when pix_valid && pix_ready.
REQ-021 Accepted byte in cycle N SHALL produce we=1, data_In=pix_data[4:0], write_address=base+count in cycle N+1 (registered outputs, latency 1).
REQ-022 we SHALL be 0 in every cycle without a write; write_address/data_In hold their last value.
REQ-023 Pixel counter SHALL run 0..SPRITE_W*SPRITE_H-1 linearly (row-major, address = base + y*SPRITE_W + x); increment only, no multiplier.
REQ-024 Address sum SHALL wrap modulo 2^ADDR_W.
REQ-025 On write of pixel SPRITE_W*SPRITE_H-1: LOAD -> DONE; pix_ready=0 from the next cycle.
REQ-026 DONE SHALL last exactly one cycle with done=1, then IDLE with busy=0.
REQ-027 pix_valid in IDLE/DONE SHALL be ignored, no write.
REQ-028 start and final write in the same cycle: start ignored (busy still 1).

Reset
REQ-029 Reset=1 SHALL force IDLE, counter=0, we=0, pix_ready=0, busy=0, done=0, write_address=0, data_In=0 on the next edge.
REQ-030 Reset mid-load SHALL abort: no further writes, no done pulse; earlier RAM contents untouched.

Configuration
REQ-031 Macro SPRITE_RLE_EN defined: accepted byte SHALL write pix_data[4:0] to (pix_data[7:5]+1) consecutive pixels, one per cycle, in RUN with pix_ready=0; return to LOAD after the run.
REQ-032 With SPRITE_RLE_EN, a run past the last pixel SHALL be truncated at the last pixel, then DONE.
REQ-033 Macro undefined: pix_data[7:5] ignored, RUN state absent, one pixel per byte.

Structure
REQ-034 Shared package SHALL hold the FSM state enum, SPRITE_W/SPRITE_H/DATA_W defaults, and the SPRITE_PIXELS constant.
REQ-035 One sub-module, sprite_addr_counter (pixel counter plus base add and last-pixel flag), is natural; everything else is flat.

Verification
REQ-036 Reset, start, base=1000, 1568 bytes pix_valid=1 -> 1568 writes at 1000..2567, done pulse one cycle after the write to 2567, busy=0 after.
REQ-037 pix_valid toggled 1/0 every cycle -> writes only for accepted bytes, addresses contiguous, no skips or duplicates.
REQ-038 start pulsed at pixel 500 -> no restart; base unchanged; load completes normally.
REQ-039 Reset at pixel 700 -> we=0 next cycle, no done; new start, base=0 -> full load from address 0.
REQ-040 SPRITE_RLE_EN, byte 0xE3 -> 8 writes of index 3, pix_ready=0 for 7 cycles; with 5 pixels remaining -> exactly 5 writes, then done.
REQ-041 base=2^19-10 -> write_address wraps to 0 after 524287.

Source files
------------

// File: rtl/sprite_ram_loader_pkg.sv
// Shared types and defaults for the sprite RAM loader.
// Optional feature macro: SPRITE_RLE_EN (run-length encoded pixel bytes).
package sprite_ram_loader_pkg;

  localparam int unsigned SPRITE_W_DEF  = 56;
  localparam int unsigned SPRITE_H_DEF  = 28;
  localparam int unsigned DATA_W_DEF    = 5;
  localparam int unsigned ADDR_W_DEF    = 19;
  localparam int unsigned SPRITE_PIXELS = SPRITE_W_DEF * SPRITE_H_DEF;

  // Source byte layout: [4:0] palette index, [7:5] run length minus one.
  localparam int unsigned PIX_BYTE_W = 8;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned RUN_W      = PIX_BYTE_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
`ifdef SPRITE_RLE_EN
    RUN  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  // Counter width able to hold indices 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_ram_loader_addr_counter.sv
// Pixel index counter with a running base+index address and last-pixel flag.
module sprite_addr_counter
  import sprite_ram_loader_pkg::*;
#(
  parameter int unsigned PIXELS = SPRITE_PIXELS,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);

  localparam int unsigned      CNT_W    = cnt_width(PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);

  logic [CNT_W-1:0] count;

  // Address tracks base+count by increment, wrapping modulo 2^ADDR_W.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
      addr  <= '0;
    end else if (load) begin
      count <= '0;
      addr  <= base;
    end else if (advance) begin
      count <= count + CNT_W'(1);
      addr  <= addr + ADDR_W'(1);
    end
  end

  assign last_c = (count == LAST_IDX);

endmodule

// File: rtl/sprite_ram_loader.sv
// Streams palette-index bytes into frame RAM for one sprite, row-major from a base address.
// Optional feature macro: SPRITE_RLE_EN (each byte repeats its index pix_data[7:5]+1 times).
module sprite_ram_loader
  import sprite_ram_loader_pkg::*;
#(
  parameter int unsigned SPRITE_W = SPRITE_W_DEF,
  parameter int unsigned SPRITE_H = SPRITE_H_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_address,
  input  logic                  pix_valid,
  input  logic [PIX_BYTE_W-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  we,
  output logic [ADDR_W-1:0]     write_address,
  output logic [DATA_W-1:0]     data_In,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PIXELS = SPRITE_W * SPRITE_H;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;
  logic                pix_ready_d, busy_d, done_d;
  logic                cnt_load, cnt_adv;
  logic [ADDR_W-1:0]   cnt_addr;
  logic                cnt_last_c;
  logic                accept;

`ifdef SPRITE_RLE_EN
  logic [RUN_W-1:0]    run_q, run_d;
  logic [DATA_W-1:0]   color_q, color_d;
`else
  logic [RUN_W-1:0]    unused_run_bits;
  assign unused_run_bits = pix_data[PIX_BYTE_W-1:IDX_W];
`endif

  assign accept = pix_valid && pix_ready;

  sprite_addr_counter #(
    .PIXELS (PIXELS),
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (cnt_load),
    .base    (base_address),
    .advance (cnt_adv),
    .addr    (cnt_addr),
    .last_c  (cnt_last_c)
  );

  // State register plus run bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
`ifdef SPRITE_RLE_EN
      run_q   <= '0;
      color_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
`ifdef SPRITE_RLE_EN
      run_q   <= run_d;
      color_q <= color_d;
`endif
    end
  end

  // Next state and next values of the registered outputs.
  // After the final pixel write, one more LOAD cycle (last_q set, pix_ready low)
  // lines the done pulse up one cycle after that write.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    we_d     = 1'b0;
    addr_d   = write_address;
    data_d   = data_In;
    cnt_load = 1'b0;
    cnt_adv  = 1'b0;
`ifdef SPRITE_RLE_EN
    run_d    = run_q;
    color_d  = color_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          cnt_load = 1'b1;
          last_d   = 1'b0;
        end
      end
      LOAD: begin
        if (last_q) begin
          state_d = DONE;
        end else if (accept) begin
          we_d    = 1'b1;
          addr_d  = cnt_addr;
          data_d  = DATA_W'(pix_data[IDX_W-1:0]);
          cnt_adv = 1'b1;
          if (cnt_last_c) begin
            last_d = 1'b1;
          end
`ifdef SPRITE_RLE_EN
          else if (pix_data[PIX_BYTE_W-1:IDX_W] != '0) begin
            run_d   = pix_data[PIX_BYTE_W-1:IDX_W];
            color_d = DATA_W'(pix_data[IDX_W-1:0]);
            state_d = RUN;
          end
`endif
        end
      end
`ifdef SPRITE_RLE_EN
      RUN: begin
        we_d    = 1'b1;
        addr_d  = cnt_addr;
        data_d  = color_q;
        cnt_adv = 1'b1;
        run_d   = run_q - RUN_W'(1);
        if (cnt_last_c) begin
          last_d  = 1'b1;
          state_d = LOAD;
        end else if (run_q == RUN_W'(1)) begin
          state_d = LOAD;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pix_ready_d = (state_d == LOAD) && !last_d;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // Registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      we            <= 1'b0;
      write_address <= '0;
      data_In       <= '0;
      pix_ready     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      we            <= we_d;
      write_address <= addr_d;
      data_In       <= data_d;
      pix_ready     <= pix_ready_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader: full loads, throttled source, ignored start,
// mid-load reset, address wrap, and RLE runs when SPRITE_RLE_EN is defined.
module tb_sprite_ram_loader;
  import sprite_ram_loader_pkg::*;

  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 5;
  localparam int          PIX = int'(SPRITE_PIXELS);
`ifdef SPRITE_RLE_EN
  localparam bit RLE = 1'b1;
`else
  localparam bit RLE = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          pix_ready;
  logic          we;
  logic [AW-1:0] write_address;
  logic [DW-1:0] data_In;
  logic          busy;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  sprite_ram_loader dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .start         (start),
    .base_address  (base_address),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_ready     (pix_ready),
    .we            (we),
    .write_address (write_address),
    .data_In       (data_In),
    .busy          (busy),
    .done          (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source byte for the pixel about to be accepted.
  function automatic logic [7:0] pat(input int n);
`ifdef SPRITE_RLE_EN
    if (n == 0 || n == PIX - 5) return 8'hE3;
    return {3'b000, 5'(n * 7 + 3)};
`else
    return {3'(n), 5'(n * 7 + 3)};
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " we"},    64'(we),        64'd0);
    check({tag, " done"},  64'(done),      64'd0);
    check({tag, " busy"},  64'(busy),      64'd0);
    check({tag, " ready"}, 64'(pix_ready), 64'd0);
  endtask

  // One sprite load with a behavioural write model; optional stray start or reset.
  task automatic run_load(input logic [AW-1:0] base, input bit toggle,
                          input int start_at, input int reset_at, input string tag);
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] cur;
    logic [7:0]    pd;
    int            n, run_left, cyc;
    bit            ready_exp, v, acc, start_used;
    n = 0; run_left = 0; cyc = 0; start_used = 1'b0; cur = '0;

    start = 1'b1; base_address = base; pix_valid = 1'b0;
    @(negedge Clk);
    start = 1'b0;
    check({tag, " start busy"},  64'(busy),      64'd1);
    check({tag, " start ready"}, 64'(pix_ready), 64'd1);
    check({tag, " start we"},    64'(we),        64'd0);
    exp_addr  = base;
    ready_exp = 1'b1;

    while (n < PIX && cyc < 4 * PIX) begin
      v  = toggle ? (cyc % 2 == 0) : 1'b1;
      pd = pat(n);
      pix_valid = v;
      pix_data  = pd;
      if (n == start_at && !start_used) begin
        start = 1'b1; base_address = ~base; start_used = 1'b1;
      end
      Reset = (n == reset_at);
      @(negedge Clk);
      cyc++;
      start = 1'b0;
      if (Reset) begin
        Reset = 1'b0;
        check({tag, " rst addr"}, 64'(write_address), 64'd0);
        check_idle_outputs({tag, " rst"});
        repeat (4) begin
          @(negedge Clk);
          check({tag, " post-rst we"},   64'(we),   64'd0);
          check({tag, " post-rst done"}, 64'(done), 64'd0);
        end
        pix_valid = 1'b0;
        return;
      end
      acc = v && ready_exp;
      if (acc) begin
        cur      = pd[DW-1:0];
        run_left = RLE ? int'(pd[7:5]) + 1 : 1;
      end
      if (run_left > 0) begin
        check({tag, " write"}, 64'({we, write_address, data_In}), 64'({1'b1, exp_addr, cur}));
        exp_addr++;
        n++;
        run_left--;
        if (n == PIX) run_left = 0;
      end else begin
        check({tag, " no write"}, 64'(we), 64'd0);
      end
      ready_exp = (n < PIX) && (run_left == 0);
      check({tag, " ready"}, 64'(pix_ready), 64'(ready_exp));
    end
    check({tag, " pixel count"}, 64'(n), 64'(PIX));

    // start coincides with the cycle showing the final write; it must be ignored.
    start = 1'b1; base_address = 19'h5; pix_valid = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    check({tag, " done"},       64'(done),      64'd1);
    check({tag, " done busy"},  64'(busy),      64'd1);
    check({tag, " done we"},    64'(we),        64'd0);
    check({tag, " done ready"}, 64'(pix_ready), 64'd0);
    @(negedge Clk);
    check_idle_outputs({tag, " after done"});
    @(negedge Clk);
    check_idle_outputs({tag, " idle"});
    pix_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'h00; base_address = '0;
    repeat (2) @(negedge Clk);
    check("reset addr", 64'(write_address), 64'd0);
    check("reset data", 64'(data_In),       64'd0);
    check_idle_outputs("reset");
    Reset = 1'b0;

    // Source bytes in IDLE must not write.
    pix_valid = 1'b1; pix_data = 8'h1F;
    repeat (3) begin
      @(negedge Clk);
      check_idle_outputs("idle pix_valid");
    end
    pix_valid = 1'b0;

    run_load(19'd1000, 1'b0, -1, -1, "full");
    run_load(19'd3000, 1'b1, -1, -1, "toggle");
    run_load(19'd200,  1'b0, 500, -1, "stray start");
    run_load(19'd4000, 1'b0, -1, 700, "reset mid");
    run_load(19'd0,    1'b0, -1, -1, "after reset");
    run_load(19'h7FFF6, 1'b0, -1, -1, "wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
